// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master: fetch side (req/addr out), slave: memory side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: one outstanding imem fetch, skid buffer, delay-slot redirect.
// Ports: clk, reset (async low), stall, redirect, npc, bus, if_id_*.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   npc,
  fetch_stage_if.master bus,
  output logic          if_id_valid,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_instr
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        tgt_valid;
  logic [31:0] tgt;

  logic        hs;
  logic        got;
  logic [31:0] npc_al;

  assign bus.imem_req  = reset & (state == IDLE)
                       & ~stall & ~buf_valid;
  assign bus.imem_addr = pc;

  assign hs     = bus.imem_req & bus.imem_ready;
  assign got    = (state == WAIT) & bus.imem_rvalid;
  assign npc_al = npc & ~32'd3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      state       <= IDLE;
      buf_valid   <= 1'b0;
      buf_pc      <= '0;
      buf_instr   <= '0;
      tgt_valid   <= 1'b0;
      tgt         <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else begin
      if (hs) begin
        inflight_pc <= pc;
        state       <= WAIT;
        tgt_valid   <= 1'b0;
        pc          <= tgt_valid ? tgt : pc + 32'd4;
      end else if (got) begin
        state <= IDLE;
      end

      // The issue in flight (or issuing now) is the
      // delay slot, so the target goes straight to pc.
      // Otherwise the target waits for one more issue.
      if (redirect) begin
        if (state == WAIT || hs) begin
          pc <= npc_al;
        end else begin
          tgt       <= npc_al;
          tgt_valid <= 1'b1;
        end
      end

      if (got && stall) begin
        buf_valid <= 1'b1;
        buf_pc    <= inflight_pc;
        buf_instr <= bus.imem_rdata;
      end

      if (!stall) begin
        unique case (1'b1)
          got: begin
            if_id_valid <= 1'b1;
            if_id_pc    <= inflight_pc;
            if_id_instr <= bus.imem_rdata;
          end
          buf_valid: begin
            if_id_valid <= 1'b1;
            if_id_pc    <= buf_pc;
            if_id_instr <= buf_instr;
            buf_valid   <= 1'b0;
          end
          default: if_id_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule
